rgb_pwm_driver: RTL and testbench

//  Downstream stage of the 8-entry colour->RGB block memory: fetches a 24-bit RGB code
//  for a selected colour and drives three 8-bit-resolution PWM outputs (R,G,B LED).
//  The block owns the memory read port (enable, address) and captures its registered output.

---
 rtl/rgb_pwm_driver_if.sv | 24 ++
 rtl/rgb_pwm_driver.sv | 188 ++++++++++++++++++
 tb/tb_rgb_pwm_driver.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_driver_if.sv
`default_nettype none
// ============================================================================
// Interface : rgb_pwm_driver_if
// Purpose   : Read port of the colour->RGB block memory (enable, address, data).
// Revision  : 1.0
// ============================================================================
interface rgb_pwm_driver_if;
    logic        mem_en;
    logic [2:0]  mem_addr;
    logic [23:0] mem_rgb;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rgb
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rgb
    );
endinterface
`default_nettype wire

// File: rtl/rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_driver
// Purpose  : Fetches a 24-bit RGB code from the colour memory and drives three
//            double-buffered 8-bit PWM outputs. Define RGB_PWM_INVERT_EN for
//            active-low (common-anode) outputs.
// Revision : 1.0
// ============================================================================
module rgb_pwm_driver #(
    parameter int PRESCALE = 1,
    parameter int MEM_LAT  = 1
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire [2:0]        colour_sel,
    input  wire              load,
    input  wire              stop,
    rgb_pwm_driver_if.master mem,
    output logic             pwm_r,
    output logic             pwm_g,
    output logic             pwm_b,
    output logic             busy,
    output logic             period_done
);

    localparam int c_PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_MAX = c_LAT_W'(MEM_LAT - 1);

`ifdef RGB_PWM_INVERT_EN
    localparam logic [2:0] c_PWM_IDLE = 3'b111;
`else
    localparam logic [2:0] c_PWM_IDLE = 3'b000;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_from_run;
    logic [7:0]           r_cnt;
    logic [c_PRE_W-1:0]   r_pre;
    logic [c_LAT_W-1:0]   r_lat;
    logic [23:0]          r_shadow;
    logic [23:0]          r_act;
    logic [2:0]           r_addr;
    logic                 r_mem_en;
    logic                 r_busy;
    logic                 r_period_done;
    logic [2:0]           r_pwm;

    state_t               w_state_nxt;
    logic                 w_from_run_nxt;
    logic [7:0]           w_cnt_nxt;
    logic [c_PRE_W-1:0]   w_pre_nxt;
    logic [c_LAT_W-1:0]   w_lat_nxt;
    logic [23:0]          w_shadow_nxt;
    logic [23:0]          w_act_nxt;
    logic [2:0]           w_addr_nxt;
    logic                 w_mem_en_nxt;
    logic                 w_running;
    logic                 w_step;
    logic                 w_wrap;
    logic                 w_live_nxt;
    logic [2:0]           w_pwm_nxt;

    // The PWM timebase keeps running through a refetch started from RUN.
    assign w_running = (r_state == S_RUN) ||
                       (r_from_run && ((r_state == S_FETCH) || (r_state == S_WAIT)));
    assign w_step    = w_running && (r_pre == c_PRE_MAX);
    assign w_wrap    = w_step && (r_cnt == 8'hFF);

    always_comb begin
        w_state_nxt    = r_state;
        w_from_run_nxt = r_from_run;
        w_cnt_nxt      = r_cnt;
        w_pre_nxt      = r_pre;
        w_lat_nxt      = r_lat;
        w_shadow_nxt   = r_shadow;
        w_act_nxt      = r_act;
        w_addr_nxt     = r_addr;
        w_mem_en_nxt   = 1'b0;

        if (w_running) begin
            if (w_step) begin
                w_pre_nxt = '0;
                w_cnt_nxt = r_cnt + 8'd1;
            end else begin
                w_pre_nxt = r_pre + 1'b1;
            end
            if (w_wrap) begin
                w_act_nxt = r_shadow;
            end
        end

        if (stop) begin
            w_state_nxt    = S_IDLE;
            w_from_run_nxt = 1'b0;
            w_cnt_nxt      = 8'd0;
            w_pre_nxt      = '0;
        end else begin
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (load) begin
                        w_state_nxt    = S_FETCH;
                        w_from_run_nxt = (r_state == S_RUN);
                        w_addr_nxt     = colour_sel;
                        w_mem_en_nxt   = 1'b1;
                    end
                end
                S_FETCH: begin
                    w_state_nxt = S_WAIT;
                    w_lat_nxt   = c_LAT_MAX;
                end
                S_WAIT: begin
                    if (r_lat == '0) begin
                        w_state_nxt    = S_RUN;
                        w_from_run_nxt = 1'b0;
                        w_shadow_nxt   = mem.mem_rgb;
                        // Fresh start applies the colour at once; a refetch waits for the wrap.
                        if (!r_from_run) begin
                            w_act_nxt = mem.mem_rgb;
                            w_cnt_nxt = 8'd0;
                            w_pre_nxt = '0;
                        end
                    end else begin
                        w_lat_nxt = r_lat - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        w_live_nxt = (w_state_nxt == S_RUN) ||
                     (w_from_run_nxt && (w_state_nxt != S_IDLE));
        w_pwm_nxt  = 3'b000;
        if (w_live_nxt) begin
            w_pwm_nxt = {(w_cnt_nxt < w_act_nxt[23:16]),
                         (w_cnt_nxt < w_act_nxt[15:8]),
                         (w_cnt_nxt < w_act_nxt[7:0])};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_from_run    <= 1'b0;
            r_cnt         <= 8'd0;
            r_pre         <= '0;
            r_lat         <= '0;
            r_shadow      <= 24'd0;
            r_act         <= 24'd0;
            r_addr        <= 3'd0;
            r_mem_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_period_done <= 1'b0;
            r_pwm         <= c_PWM_IDLE;
        end else begin
            r_state       <= w_state_nxt;
            r_from_run    <= w_from_run_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pre         <= w_pre_nxt;
            r_lat         <= w_lat_nxt;
            r_shadow      <= w_shadow_nxt;
            r_act         <= w_act_nxt;
            r_addr        <= w_addr_nxt;
            r_mem_en      <= w_mem_en_nxt;
            r_busy        <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_WAIT);
            r_period_done <= w_wrap;
            r_pwm         <= w_pwm_nxt ^ c_PWM_IDLE;
        end
    end

    assign mem.mem_en   = r_mem_en;
    assign mem.mem_addr = r_addr;
    assign pwm_r        = r_pwm[2];
    assign pwm_g        = r_pwm[1];
    assign pwm_b        = r_pwm[0];
    assign busy         = r_busy;
    assign period_done  = r_period_done;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pwm_driver
// Purpose  : Randomised scoreboard bench for rgb_pwm_driver with a timeline
//            reference model; honours RGB_PWM_INVERT_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rgb_pwm_driver;

    localparam int PRESCALE = 1;
    localparam int MEM_LAT  = 1;
    localparam int c_PER    = 256 * PRESCALE;
`ifdef RGB_PWM_INVERT_EN
    localparam logic c_INV = 1'b1;
`else
    localparam logic c_INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] colour_sel = 3'd0;
    logic       pwm_r, pwm_g, pwm_b, busy, period_done;

    rgb_pwm_driver_if mem_bus ();

    rgb_pwm_driver #(.PRESCALE(PRESCALE), .MEM_LAT(MEM_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .colour_sel  (colour_sel),
        .load        (load),
        .stop        (stop),
        .mem         (mem_bus),
        .pwm_r       (pwm_r),
        .pwm_g       (pwm_g),
        .pwm_b       (pwm_b),
        .busy        (busy),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    // Registered-read colour memory.
    logic [23:0] tbl [8];
    always @(posedge clk) begin
        if (mem_bus.mem_en) mem_bus.mem_rgb <= tbl[mem_bus.mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    endtask

    // Reference model: a timeline of run start, fetch completion and period boundaries.
    typedef struct { int cyc; logic [2:0] addr; } mem_ev_t;
    typedef struct { int cyc; logic [23:0] duty; } pd_ev_t;
    mem_ev_t mem_q [$];
    pd_ev_t  pd_q  [$];

    bit          m_run = 0, m_fetch = 0, m_from_run = 0, m_pend_v = 0;
    int          m_s = 0, m_done = 0;
    logic [2:0]  m_addr = 3'd0, m_faddr = 3'd0;
    logic [23:0] m_act = 24'd0, m_pend = 24'd0;

    function automatic void m_reset();
        m_run = 0; m_fetch = 0; m_from_run = 0; m_pend_v = 0;
        m_addr = 3'd0; m_act = 24'd0;
        mem_q.delete();
        pd_q.delete();
    endfunction

    initial forever begin
        @(negedge rst_n);
        m_reset();
    end

    initial begin : model
        mem_ev_t me;
        pd_ev_t  pe;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_reset();
            end else begin
                if (m_run && cyc > m_s && ((cyc - m_s) % c_PER) == 0) begin
                    pe.cyc = cyc; pe.duty = m_act;
                    pd_q.push_back(pe);
                    if (m_pend_v) begin m_act = m_pend; m_pend_v = 0; end
                end
                if (stop) begin
                    m_run = 0; m_fetch = 0; m_pend_v = 0;
                end else if (m_fetch && cyc == m_done) begin
                    m_fetch = 0;
                    if (m_from_run) begin
                        m_pend = tbl[m_faddr]; m_pend_v = 1;
                    end else begin
                        m_run = 1; m_s = cyc; m_act = tbl[m_faddr];
                    end
                end else if (load && !m_fetch) begin
                    m_fetch = 1; m_from_run = m_run;
                    m_addr = colour_sel; m_faddr = colour_sel;
                    m_done = cyc + 1 + MEM_LAT;
                    me.cyc = cyc; me.addr = colour_sel;
                    mem_q.push_back(me);
                end
            end
        end
    end

    // Monitor: per-cycle output check plus scoreboard pops on mem_en / period_done.
    logic [2:0] hist [c_PER];
    initial begin : monitor
        logic [2:0] p, exp_p;
        int         ph, cr, cg, cb;
        mem_ev_t    me;
        pd_ev_t     pe;
        for (int i = 0; i < c_PER; i++) hist[i] = 3'b000;
        forever begin
            @(negedge clk);
            p     = {pwm_r, pwm_g, pwm_b} ^ {3{c_INV}};
            exp_p = 3'b000;
            if (m_run) begin
                ph    = ((cyc - m_s) / PRESCALE) % 256;
                exp_p = {ph < int'(m_act[23:16]), ph < int'(m_act[15:8]), ph < int'(m_act[7:0])};
            end
            check("outputs{busy,addr,pwm}", {busy, mem_bus.mem_addr, p}, {m_fetch, m_addr, exp_p});

            if (mem_bus.mem_en) begin
                if (mem_q.size() == 0) begin
                    check("mem_en_unexpected", mem_bus.mem_en, 1'b0);
                end else begin
                    me = mem_q.pop_front();
                    check("mem_en_cycle", cyc, me.cyc);
                    check("mem_addr_fetch", mem_bus.mem_addr, me.addr);
                end
            end else if (mem_q.size() > 0 && mem_q[0].cyc < cyc) begin
                check("mem_en_missing", mem_bus.mem_en, 1'b1);
                void'(mem_q.pop_front());
            end

            if (period_done) begin
                if (pd_q.size() == 0) begin
                    check("period_done_unexpected", period_done, 1'b0);
                end else begin
                    pe = pd_q.pop_front();
                    cr = 0; cg = 0; cb = 0;
                    for (int i = 0; i < c_PER; i++) begin
                        cr += hist[i][2]; cg += hist[i][1]; cb += hist[i][0];
                    end
                    check("period_cycle", cyc, pe.cyc);
                    check("period_r_high", cr, int'(pe.duty[23:16]) * PRESCALE);
                    check("period_g_high", cg, int'(pe.duty[15:8]) * PRESCALE);
                    check("period_b_high", cb, int'(pe.duty[7:0]) * PRESCALE);
                end
            end else if (pd_q.size() > 0 && pd_q[0].cyc < cyc) begin
                check("period_done_missing", period_done, 1'b1);
                void'(pd_q.pop_front());
            end
            hist[cyc % c_PER] = p;
        end
    end

    task automatic drive(input logic l, input logic s, input logic [2:0] col);
        @(negedge clk);
        load = l; stop = s; colour_sel = col;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'($urandom));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int r;
        for (int i = 0; i < 8; i++) tbl[i] = 24'($urandom);
        tbl[4] = 24'hFF8000;
        tbl[1] = 24'h00FF00;
        tbl[2] = 24'h000000;

        repeat (3) @(negedge clk);
        check("reset_state", {pwm_r, pwm_g, pwm_b, busy, period_done, mem_bus.mem_en, mem_bus.mem_addr},
              {{3{c_INV}}, 3'b000, 3'd0});
        rst_n = 1'b1;
        idle(5);

        drive(1'b1, 1'b0, 3'd4);          // fresh start, colour 4
        idle(3 * c_PER + 20);
        drive(1'b1, 1'b0, 3'd1);          // refetch mid-period
        idle(3 * c_PER + 10);
        drive(1'b1, 1'b0, 3'd4);          // load then load-while-busy
        drive(1'b1, 1'b0, 3'd2);
        idle(2 * c_PER + 50);
        drive(1'b1, 1'b1, 3'd2);          // stop beats load
        idle(20);

        drive(1'b1, 1'b0, 3'd4);          // async reset while in WAIT
        @(posedge clk); #1 load = 1'b0;
        @(posedge clk); #1;
        check("busy_in_wait", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("async_reset", {pwm_r, pwm_g, pwm_b, busy, period_done, mem_bus.mem_en, mem_bus.mem_addr},
                 {{3{c_INV}}, 3'b000, 3'd0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 3'd2);
        idle(c_PER + 50);

        for (int i = 0; i < 8000; i++) begin
            r = $urandom_range(0, 999);
            if (i == 4000) begin
                @(posedge clk); #2 rst_n = 1'b0;
                @(negedge clk); rst_n = 1'b1;
            end
            if (r < 5)        drive(1'b1, 1'b0, 3'($urandom));
            else if (r == 5)  begin drive(1'b1, 1'b0, 3'($urandom)); drive(1'b1, 1'b0, 3'($urandom)); end
            else if (r == 6)  drive(1'b1, 1'b1, 3'($urandom));
            else if (r >= 998) drive(1'b0, 1'b1, 3'($urandom));
            else              drive(1'b0, 1'b0, 3'($urandom));
        end

        drive(1'b0, 1'b1, 3'd0);
        idle(4);
        check("mem_queue_drained", mem_q.size(), 0);
        check("period_queue_drained", pd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
